// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default bit period, parity type.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT_DEF = 870;

  // Parity sense: 0 = even (XOR of data bits), 1 = odd.
  localparam logic UART_PARITY_EVEN = 1'b0;
  localparam logic UART_PARITY_ODD  = 1'b1;
  localparam logic UART_PARITY_TYPE = UART_PARITY_EVEN;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic uart_parity(input logic [7:0] data,
                                       input logic       ptype = UART_PARITY_TYPE);
    return (^data) ^ ptype;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Transmit request/status bundle between a byte producer and uart_tx.
// The producer strobes i_Tx_DV for one cycle while o_Tx_Ready is high.
interface uart_tx_if;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Serial;
  logic       o_Tx_Active;
  logic       o_Tx_Ready;
  logic       o_Tx_Done;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Serial, o_Tx_Active, o_Tx_Ready, o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Serial, o_Tx_Active, o_Tx_Ready, o_Tx_Done
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// Per-bit clock counter: counts 0..CLKS_PER_BIT-1 while enabled, wraps at the bit boundary.
// Terminal-count pulse is combinational in the last cycle of each bit; clear has priority.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 870
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tc = enable && (cnt_q == CNT_MAX);

  always_ff @(posedge i_Clock) begin
    if (i_Reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity (UART_TX_PARITY_EN), stop.
// Line goes low the cycle after an accepted i_Tx_DV; requests while busy are dropped.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic      i_Clock,
  input  logic      i_Reset,
  uart_tx_if.slave  tx
);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        serial_q, serial_d;
  logic        active_q, done_q;
  logic        baud_clr, baud_en, baud_tc;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .clear   (baud_clr),
    .enable  (baud_en),
    .tc      (baud_tc)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    baud_clr  = 1'b0;
    baud_en   = (state_q != ST_IDLE);
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_clr = 1'b1;
        if (tx.i_Tx_DV) begin
          state_d   = ST_START;
          shift_d   = tx.i_Tx_Byte;
          bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_d  = uart_parity(tx.i_Tx_Byte);
`endif
        end
      end
      ST_START: begin
        if (baud_tc) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (baud_tc) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tc) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (baud_tc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is decoded from the next state so the register leads the state by nothing.
    serial_d = 1'b1;
    case (state_d)
      ST_START:  serial_d = 1'b0;
      ST_DATA:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: serial_d = parity_q;
`endif
      default:   serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      serial_q  <= serial_d;
      active_q  <= (state_d != ST_IDLE);
      done_q    <= (state_q == ST_STOP) && baud_tc;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx.o_Tx_Serial = serial_q;
  assign tx.o_Tx_Active = active_q;
  assign tx.o_Tx_Done   = done_q;
  assign tx.o_Tx_Ready  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed scoreboard bench for uart_tx: fast instance (4 clk/bit) and a full-rate instance (870 clk/bit).
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB      = 4;
  localparam int CPB_SLOW = 870;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk = 1'b0;
  logic rst;

  uart_tx_if fast_if ();
  uart_tx_if slow_if ();

  uart_tx #(.CLKS_PER_BIT(CPB)) u_dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .tx      (fast_if.slave)
  );

  uart_tx #(.CLKS_PER_BIT(CPB_SLOW)) u_dut_slow (
    .i_Clock (clk),
    .i_Reset (rst),
    .tx      (slow_if.slave)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit slow,
                         input logic s, input logic a, input logic d, input logic r);
    chk1({tag, "_serial"}, slow ? slow_if.o_Tx_Serial : fast_if.o_Tx_Serial, s);
    chk1({tag, "_active"}, slow ? slow_if.o_Tx_Active : fast_if.o_Tx_Active, a);
    chk1({tag, "_done"},   slow ? slow_if.o_Tx_Done   : fast_if.o_Tx_Done,   d);
    chk1({tag, "_ready"},  slow ? slow_if.o_Tx_Ready  : fast_if.o_Tx_Ready,  r);
  endtask

  // Reference line level for bit slot idx of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic send_fast(input logic [7:0] b);
    fast_if.i_Tx_DV   = 1'b1;
    fast_if.i_Tx_Byte = b;
    exp_q.push_back(b);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fast_if.i_Tx_DV = 1'b0;
      chk_out(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
  endtask

  // Checks one whole frame cycle by cycle, starting the cycle after DV was sampled.
  task automatic run_frame(input string tag, input bit chain, input logic [7:0] nxt,
                           input bit inject, input logic [7:0] junk);
    logic [7:0] b;
    b = exp_q.pop_front();
    for (int s = 1; s <= NBITS * CPB; s++) begin
      @(negedge clk);
      fast_if.i_Tx_DV = 1'b0;
      chk_out(tag, 1'b0, frame_bit(b, (s - 1) / CPB), 1'b1, 1'b0, 1'b0);
      if (inject && (s == 6 || s == 23)) begin
        fast_if.i_Tx_DV   = 1'b1;
        fast_if.i_Tx_Byte = junk;
      end
    end
    @(negedge clk);
    fast_if.i_Tx_DV = 1'b0;
    chk_out({tag, "_end"}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    if (chain) send_fast(nxt);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] rx;

    rst               = 1'b1;
    fast_if.i_Tx_DV   = 1'b0;
    fast_if.i_Tx_Byte = 8'h00;
    slow_if.i_Tx_DV   = 1'b0;
    slow_if.i_Tx_Byte = 8'h00;
    repeat (3) @(negedge clk);
    chk_out("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_out("reset_slow", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    idle_cycles("idle", 2);

    // Single frame, Done on the 41st sample after DV.
    @(negedge clk);
    send_fast(8'hA5);
    run_frame("a5", 1'b0, 8'h00, 1'b0, 8'h00);
    idle_cycles("a5_after", 3);

    // Back-to-back: DV on the Done cycle.
    @(negedge clk);
    send_fast(8'h00);
    run_frame("b2b_00", 1'b1, 8'hFF, 1'b0, 8'h00);
    run_frame("b2b_ff", 1'b0, 8'h00, 1'b0, 8'h00);
    idle_cycles("b2b_after", 3);

    // Requests while busy are dropped.
    @(negedge clk);
    send_fast(8'h81);
    run_frame("busy_81", 1'b0, 8'h00, 1'b1, 8'h3C);
    idle_cycles("busy_after", NBITS * CPB + 5);
    chk32("busy_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 3 abandons the frame; DV coincident with reset is ignored.
    @(negedge clk);
    send_fast(8'h55);
    b = exp_q.pop_front();
    for (int s = 1; s <= 18; s++) begin
      @(negedge clk);
      fast_if.i_Tx_DV = 1'b0;
      chk_out("rst55_pre", 1'b0, frame_bit(b, (s - 1) / CPB), 1'b1, 1'b0, 1'b0);
    end
    rst               = 1'b1;
    fast_if.i_Tx_DV   = 1'b1;
    fast_if.i_Tx_Byte = 8'hF0;
    @(negedge clk);
    rst             = 1'b0;
    fast_if.i_Tx_DV = 1'b0;
    chk_out("rst55_abort", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_cycles("rst55_quiet", NBITS * CPB + 5);

    // DV while idle but under reset must not start a frame.
    @(negedge clk);
    rst               = 1'b1;
    fast_if.i_Tx_DV   = 1'b1;
    fast_if.i_Tx_Byte = 8'h0F;
    @(negedge clk);
    rst             = 1'b0;
    fast_if.i_Tx_DV = 1'b0;
    chk_out("rst_dv", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_cycles("rst_dv_quiet", NBITS * CPB + 5);

    @(negedge clk);
    send_fast(8'h55);
    run_frame("after_rst_55", 1'b0, 8'h00, 1'b0, 8'h00);

    // Parity-sensitive patterns (ordinary frames when parity is off).
    @(negedge clk);
    send_fast(8'h07);
    run_frame("par_07", 1'b1, 8'h03, 1'b0, 8'h00);
    run_frame("par_03", 1'b0, 8'h00, 1'b0, 8'h00);
    idle_cycles("par_after", 3);

    // Full-rate instance: every bit exactly 870 cycles; sample mid-bit as a receiver would.
    @(negedge clk);
    slow_if.i_Tx_DV   = 1'b1;
    slow_if.i_Tx_Byte = 8'h5A;
    exp_q.push_back(8'h5A);
    b  = exp_q.pop_front();
    rx = 8'h00;
    for (int s = 1; s <= NBITS * CPB_SLOW; s++) begin
      @(negedge clk);
      slow_if.i_Tx_DV = 1'b0;
      chk1("slow_serial", slow_if.o_Tx_Serial, frame_bit(b, (s - 1) / CPB_SLOW));
      chk1("slow_done", slow_if.o_Tx_Done, 1'b0);
      if (((s - 1) % CPB_SLOW) == CPB_SLOW / 2 && (s - 1) / CPB_SLOW >= 1
          && (s - 1) / CPB_SLOW <= 8)
        rx = {slow_if.o_Tx_Serial, rx[7:1]};
    end
    @(negedge clk);
    chk_out("slow_end", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk32("slow_loopback", 32'(rx), 32'(b));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 870, SHALL set clock cycles per serial bit (i_Clock frequency / baud rate); legal range 2..65535.
REQ-002 i_Clock  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-003 i_Reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 i_Tx_DV  input  1  SHALL request transmission of i_Tx_Byte; single-cycle strobe.
REQ-005 i_Tx_Byte  input  8  SHALL carry the data byte, sampled only in the accept cycle.
REQ-006 o_Tx_Serial  output  1  SHALL be the serial line; idle-high.
REQ-007 o_Tx_Active  output  1  SHALL be high while a frame is on the line (START through STOP).
REQ-008 o_Tx_Ready  output  1  SHALL be high exactly when the FSM is in IDLE.
REQ-009 o_Tx_Done  output  1  SHALL pulse high for one cycle when a frame completes.

Function
REQ-010 Frame SHALL be 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE: o_Tx_Serial=1; if i_Tx_DV=1, latch i_Tx_Byte into a shift register, clear bit counter and clock counter, go to START.
REQ-013 i_Tx_DV SHALL be ignored outside IDLE; a byte presented while busy SHALL be dropped without corrupting the current frame.
REQ-014 Latency: i_Tx_DV high in cycle N (IDLE) -> o_Tx_Serial=0 and o_Tx_Active=1 from cycle N+1.
REQ-015 Every bit SHALL be driven for exactly CLKS_PER_BIT cycles; clock counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
REQ-016 Clock counter width SHALL be $clog2(CLKS_PER_BIT) bits minimum; it must never truncate CLKS_PER_BIT-1.
REQ-017 DATA: bit index 0..7; at index 7 terminal count go to PARITY (macro defined) else STOP.
REQ-018 STOP: drive 1 for CLKS_PER_BIT cycles; at terminal count go to IDLE, o_Tx_Active=0, o_Tx_Done=1 in that same next cycle.
REQ-019 Frame duration SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-020 Back-to-back: i_Tx_DV asserted in the cycle o_Tx_Done=1 SHALL be accepted; next start bit begins the following cycle (one idle-high cycle between frames).
REQ-021 o_Tx_Serial SHALL be driven from a register (glitch-free).

Reset
REQ-022 On i_Reset=1: state IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1 (combinational from IDLE), counters and shift register 0.
REQ-023 Reset mid-frame SHALL abandon the frame: line high in the cycle after reset sampled, no o_Tx_Done pulse.
REQ-024 i_Tx_DV coincident with i_Reset SHALL be ignored.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: PARITY state enabled, drives even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles between DATA and STOP.
REQ-026 Macro undefined: PARITY state and parity logic absent; DATA goes directly to STOP.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state encodings, default CLKS_PER_BIT (870) and the parity-type constant, shared with the receiver.
REQ-028 Sub-module uart_baud_cnt SHALL implement the per-bit clock counter (inputs: clear, enable; output: terminal-count pulse), reusable by the receiver.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-029 Send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; o_Tx_Done one cycle at cycle 41 after DV.
REQ-030 Send 0x00 then 0xFF back-to-back (DV on Done cycle) -> exactly one idle-high cycle between frames, both bytes correct, two Done pulses.
REQ-031 Assert DV with 0x3C while sending 0x81 -> 0x81 transmitted intact, 0x3C never appears, one Done pulse.
REQ-032 Assert i_Reset at data bit 3 of 0x55 -> line high next cycle, Active=0, Ready=1, no Done; subsequent 0x55 sent correctly.
REQ-033 UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1, frame 44 cycles; 0x03 -> parity bit 0.
REQ-034 CLKS_PER_BIT=870, send 0x5A -> each bit exactly 870 cycles (counter width check); loopback through the receiver returns 0x5A.
